ahb3_master_seq: RTL and testbench

- AHB-lite master front end that sits directly upstream of ahb3lite_top (the slave/memory) and drives its i_HADDR/i_HWRITE/i_HTRANS/i_HSIZE/i_HBURST/i_HWDATA bus.
- Accepts single-word or INCR4 read/write commands on a valid/ready port and buffers write beats in a small FIFO.
- Issues pipelined address/data phases, honours HREADY, and returns read data on a streaming output.
- Replaces hand-driven bus stimulus so the environment can exercise the slave with legal, back-to-back traffic.

---
 rtl/ahb3_master_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_ahb3_master_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3_master_seq.sv
// ahb3_master_seq: AHB-lite master front end for ahb3lite_top.
//
// Turns SINGLE / INCR4 read and write commands into pipelined AHB-lite
// address and data phases. Write beats are buffered in a small FIFO, and a
// command is launched only when all of its write data is already buffered,
// so BUSY is never issued. Read beats come back on a one-cycle streaming
// output.
//
// Ports:
//   clk, reset              bus clock; synchronous active-high reset
//   cmd_valid/ready         command handshake
//   cmd_write, cmd_burst,   direction (1 = write), burst (0 = SINGLE,
//   cmd_addr                1 = INCR4) and start byte address
//   cmd_err                 one-cycle pulse: the accepted command was dropped
//   wd_valid/ready, wd_data write-beat FIFO push port
//   i_HADDR ... i_HWDATA    AHB-lite master outputs
//   HREADY, i_HRDATA        AHB-lite slave response
//   rd_valid, rd_data,      read beat stream; rd_last marks the final beat
//   rd_last                 of a command
module ahb3_master_seq #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_burst,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_err,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic [ADDR_W-1:0] i_HADDR,
    output logic              i_HWRITE,
    output logic [1:0]        i_HTRANS,
    output logic [2:0]        i_HSIZE,
    output logic [2:0]        i_HBURST,
    output logic [DATA_W-1:0] i_HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] i_HRDATA,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam int PTR_W = (WD_DEPTH > 1) ? $clog2(WD_DEPTH) : 1;
    localparam int CNT_W = $clog2(WD_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_SEQB  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR4  = 3'b011;

    logic [1:0]        state;
    logic [1:0]        beat;
    logic [1:0]        beat_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_addr;

    logic              dp_valid;
    logic              dp_write;
    logic              dp_last;

    logic [DATA_W-1:0] fifo_mem [WD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  avail;

    logic addr_accept;
    logic last_beat;
    logic final_addr;
    logic pop;
    logic push;
    logic data_ok;
    logic accept;
    logic illegal;
    logic launch;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign i_HSIZE = 3'b010;

    always_comb begin
        addr_accept = HREADY && i_HTRANS[1];
        last_beat   = ((state == S_ADDR) && (i_HBURST == HB_SINGLE)) ||
                      ((state == S_SEQB) && (beat == 2'd3));
        final_addr  = addr_accept && last_beat;
        pop         = addr_accept && i_HWRITE;
        push        = wd_valid && wd_ready;
        // Beats left for the next command once this cycle's pop is taken;
        // pushes in flight are ignored, which only delays a launch.
        avail       = count - CNT_W'(pop);
        data_ok     = !cmd_write || (avail >= CNT_W'(4)) ||
                      (!cmd_burst && (avail != '0));
        cmd_ready   = !reset && ((state == S_IDLE) || final_addr) && data_ok;
        accept      = cmd_valid && cmd_ready;
        illegal     = (cmd_addr[1:0] != 2'b00) ||
                      (cmd_burst && (cmd_addr[9:0] > 10'h3F0));
        launch      = accept && !illegal;
        // A full FIFO can still take a beat in the cycle one is popped.
        wd_ready    = (count != CNT_W'(WD_DEPTH)) || pop;
        beat_nxt    = beat + 2'd1;
        next_addr   = base + {{(ADDR_W-4){1'b0}}, beat_nxt, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= wd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            beat     <= '0;
            base     <= '0;
            i_HADDR  <= '0;
            i_HWRITE <= 1'b0;
            i_HTRANS <= TR_IDLE;
            i_HBURST <= HB_SINGLE;
            i_HWDATA <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            cmd_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            cmd_err <= accept && illegal;

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                i_HWDATA <= fifo_mem[rd_ptr];
                rd_ptr   <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Data-phase tracking: the phase accepted now is the one whose
            // data completes at the next HREADY.
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (HREADY) begin
                dp_valid <= i_HTRANS[1];
                dp_write <= i_HWRITE;
                dp_last  <= last_beat;
                if (dp_valid && !dp_write) begin
                    rd_valid <= 1'b1;
                    rd_data  <= i_HRDATA;
                    rd_last  <= dp_last;
                end
            end

            // launch can only be true in IDLE or on the final address phase,
            // so letting it override the per-state moves is safe.
            if (launch) begin
                state    <= S_ADDR;
                beat     <= '0;
                base     <= cmd_addr;
                i_HADDR  <= cmd_addr;
                i_HWRITE <= cmd_write;
                i_HTRANS <= TR_NONSEQ;
                i_HBURST <= cmd_burst ? HB_INCR4 : HB_SINGLE;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (HREADY) begin
                            if (i_HBURST == HB_INCR4) begin
                                state    <= S_SEQB;
                                beat     <= beat_nxt;
                                i_HADDR  <= next_addr;
                                i_HTRANS <= TR_SEQ;
                            end else begin
                                state    <= S_DRAIN;
                                i_HTRANS <= TR_IDLE;
                            end
                        end
                    end
                    S_SEQB: begin
                        if (HREADY) begin
                            if (beat == 2'd3) begin
                                state    <= S_DRAIN;
                                i_HTRANS <= TR_IDLE;
                            end else begin
                                beat    <= beat_nxt;
                                i_HADDR <= next_addr;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (HREADY) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb3_master_seq.sv
// Scoreboard bench for ahb3_master_seq. Stimulus pushes expected address
// phases, write data, read beats and error pulses into queues; a negedge
// monitor pops and compares as the DUT presents them. A tiny memory model
// plays the AHB slave.
module tb_ahb3_master_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_burst, cmd_err;
    logic [31:0] cmd_addr;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [31:0] i_HADDR, i_HWDATA, i_HRDATA, rd_data;
    logic        i_HWRITE, HREADY, rd_valid, rd_last;
    logic [1:0]  i_HTRANS;
    logic [2:0]  i_HSIZE, i_HBURST;

    ahb3_master_seq #(.ADDR_W(32), .DATA_W(32), .WD_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_err(cmd_err),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .i_HADDR(i_HADDR), .i_HWRITE(i_HWRITE), .i_HTRANS(i_HTRANS),
        .i_HSIZE(i_HSIZE), .i_HBURST(i_HBURST), .i_HWDATA(i_HWDATA),
        .HREADY(HREADY), .i_HRDATA(i_HRDATA),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    // Slave memory model.
    logic [31:0] mem [1024];
    logic        s_act, s_wr;
    logic [31:0] s_addr;
    always @(posedge clk) begin
        if (reset) begin
            s_act <= 1'b0;
        end else if (HREADY) begin
            if (s_act && s_wr) mem[s_addr[11:2]] <= i_HWDATA;
            s_act  <= i_HTRANS[1];
            s_wr   <= i_HWRITE;
            s_addr <= i_HADDR;
        end
    end
    assign i_HRDATA = (s_act && !s_wr) ? mem[s_addr[11:2]] : 32'hDEAD_BEEF;

    int n_total = 0;
    int n_pass  = 0;
    logic [40:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [32:0] exp_rd[$];
    int exp_err = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [40:0] ph(input logic [31:0] a, input logic [1:0] t,
                                       input logic [2:0] b, input logic w);
        return {a, t, b, w, 3'b010};
    endfunction

    // Monitor.
    logic        mon_wr = 1'b0;
    logic [40:0] act_ph;
    always @(negedge clk) begin
        if (reset) begin
            mon_wr = 1'b0;
        end else begin
            if (i_HTRANS != 2'b00) begin
                act_ph = {i_HADDR, i_HTRANS, i_HBURST, i_HWRITE, i_HSIZE};
                if (exp_addr.size() == 0) begin
                    check(1'b0, "addr_phase_unexpected", 64'(act_ph), 64'd0);
                end else begin
                    check(act_ph == exp_addr[0], "addr_phase", 64'(act_ph), 64'(exp_addr[0]));
                    if (HREADY) void'(exp_addr.pop_front());
                end
            end
            if (mon_wr && HREADY) begin
                if (exp_wdata.size() == 0) begin
                    check(1'b0, "wdata_unexpected", 64'(i_HWDATA), 64'd0);
                end else begin
                    check(i_HWDATA == exp_wdata[0], "hwdata", 64'(i_HWDATA), 64'(exp_wdata[0]));
                    void'(exp_wdata.pop_front());
                end
            end
            if (HREADY) mon_wr = i_HTRANS[1] && i_HWRITE;
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check(1'b0, "rd_unexpected", 64'({rd_last, rd_data}), 64'd0);
                end else begin
                    check({rd_last, rd_data} == exp_rd[0], "rd_beat",
                          64'({rd_last, rd_data}), 64'(exp_rd[0]));
                    void'(exp_rd.pop_front());
                end
            end
            if (cmd_err) begin
                check(exp_err > 0, "cmd_err_unexpected", 64'd1, 64'(exp_err));
                if (exp_err > 0) exp_err--;
            end
        end
    end

    // All stimulus tasks start and end at posedge + 1.
    task automatic issue(input logic w, input logic b, input logic [31:0] a);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_burst = b; cmd_addr = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) check(1'b0, "cmd_ready_timeout", 64'(a), 64'd1);
    endtask

    task automatic push_wd(input logic [31:0] d);
        bit ok = 1'b0;
        exp_wdata.push_back(d);
        wd_valid = 1'b1; wd_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wd_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        wd_valid = 1'b0;
        if (!ok) check(1'b0, "wd_ready_timeout", 64'(d), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (exp_addr.size() == 0 && exp_wdata.size() == 0 &&
                exp_rd.size() == 0 && exp_err == 0) break;
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        check(exp_addr.size() == 0 && exp_wdata.size() == 0 &&
              exp_rd.size() == 0 && exp_err == 0, "queues_drained",
              64'(exp_addr.size() + exp_wdata.size() + exp_rd.size() + exp_err), 64'd0);
    endtask

    task automatic exp_incr4(input logic [31:0] a, input logic w);
        exp_addr.push_back(ph(a, 2'b10, 3'b011, w));
        for (int i = 1; i < 4; i++) exp_addr.push_back(ph(a + 32'(4 * i), 2'b11, 3'b011, w));
    endtask

    logic [31:0] d[4];
    logic [31:0] e[4];
    bit found;

    initial begin
        d[0] = 32'hC0DE_0000; d[1] = 32'hC0DE_0011; d[2] = 32'hC0DE_0022; d[3] = 32'hC0DE_0033;
        e[0] = 32'hE000_00E0; e[1] = 32'hE000_00E1; e[2] = 32'hE000_00E2; e[3] = 32'hE000_00E3;
        reset = 1'b1; HREADY = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b1; cmd_burst = 1'b0; cmd_addr = '0;
        wd_valid = 1'b0; wd_data = '0;
        repeat (3) @(posedge clk); #1;
        check(cmd_ready == 1'b0, "cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check({i_HTRANS, i_HADDR, i_HWRITE, i_HBURST, i_HWDATA} == '0, "reset_bus",
              64'({i_HTRANS, i_HADDR}), 64'd0);
        check({rd_valid, rd_last, cmd_err} == 3'b000, "reset_flags",
              64'({rd_valid, rd_last, cmd_err}), 64'd0);
        // FIFO empty: a SINGLE write must not be ready, a read must be.
        check(cmd_ready == 1'b0 && wd_ready == 1'b1, "reset_fifo_empty",
              64'({cmd_ready, wd_ready}), 64'b01);
        cmd_write = 1'b0;
        #1 check(cmd_ready == 1'b1, "read_ready_idle", 64'(cmd_ready), 64'd1);

        // Write SINGLE.
        push_wd(32'hA5A5_0001);
        exp_addr.push_back(ph(32'h10, 2'b10, 3'b000, 1'b1));
        issue(1'b1, 1'b0, 32'h10);
        wait_idle();

        // Write INCR4 at 0x100.
        for (int i = 0; i < 4; i++) push_wd(d[i]);
        exp_incr4(32'h100, 1'b1);
        issue(1'b1, 1'b1, 32'h100);
        wait_idle();

        // Read INCR4 back.
        exp_incr4(32'h100, 1'b0);
        for (int i = 0; i < 4; i++) exp_rd.push_back({i == 3, d[i]});
        issue(1'b0, 1'b1, 32'h100);
        wait_idle();

        // Read INCR4 with a 2-cycle stall on beat 1.
        exp_incr4(32'h100, 1'b0);
        for (int i = 0; i < 4; i++) exp_rd.push_back({i == 3, d[i]});
        issue(1'b0, 1'b1, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i_HTRANS == 2'b11 && i_HADDR == 32'h104) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check(found, "stall_beat1_seen", 64'(i_HADDR), 64'h104);
        HREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check(rd_valid == 1'b0, "no_rd_in_stall", 64'(rd_valid), 64'd0);
            @(posedge clk); #1;
        end
        HREADY = 1'b1;
        wait_idle();

        // Read SINGLE of the earlier write.
        exp_addr.push_back(ph(32'h10, 2'b10, 3'b000, 1'b0));
        exp_rd.push_back({1'b1, 32'hA5A5_0001});
        issue(1'b0, 1'b0, 32'h10);
        wait_idle();

        // Illegal commands.
        exp_err++;
        issue(1'b0, 1'b1, 32'h3F4);
        wait_idle();
        exp_err++;
        issue(1'b0, 1'b0, 32'h21);
        wait_idle();

        // INCR4 at the last legal start of a 1 KB page, then read beat 3.
        for (int i = 0; i < 4; i++) push_wd(e[i]);
        exp_incr4(32'h3F0, 1'b1);
        issue(1'b1, 1'b1, 32'h3F0);
        wait_idle();
        exp_addr.push_back(ph(32'h3FC, 2'b10, 3'b000, 1'b0));
        exp_rd.push_back({1'b1, e[3]});
        issue(1'b0, 1'b0, 32'h3FC);
        wait_idle();

        // Back-to-back write then read of the same word.
        push_wd(32'h5555_AAAA);
        exp_addr.push_back(ph(32'h20, 2'b10, 3'b000, 1'b1));
        exp_addr.push_back(ph(32'h20, 2'b10, 3'b000, 1'b0));
        exp_rd.push_back({1'b1, 32'h5555_AAAA});
        issue(1'b1, 1'b0, 32'h20);
        issue(1'b0, 1'b0, 32'h20);
        wait_idle();

        // Reset during beat 2 of an INCR4 write.
        for (int i = 0; i < 4; i++) push_wd(32'hBAD0_0000 + 32'(i));
        exp_incr4(32'h200, 1'b1);
        issue(1'b1, 1'b1, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i_HTRANS == 2'b11 && i_HADDR == 32'h208) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check(found, "reset_beat2_seen", 64'(i_HADDR), 64'h208);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_addr.delete(); exp_wdata.delete();
        check(i_HTRANS == 2'b00 && i_HADDR == 32'h0, "reset_mid_burst_bus",
              64'({i_HTRANS, i_HADDR}), 64'd0);
        check(rd_valid == 1'b0, "reset_mid_burst_rd", 64'(rd_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        cmd_write = 1'b1; cmd_burst = 1'b0;
        #1 check(cmd_ready == 1'b0 && wd_ready == 1'b1, "reset_mid_burst_fifo_empty",
                 64'({cmd_ready, wd_ready}), 64'b01);
        exp_addr.push_back(ph(32'h100, 2'b10, 3'b000, 1'b0));
        exp_rd.push_back({1'b1, d[0]});
        issue(1'b0, 1'b0, 32'h100);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
